// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// frame shape constants and the default bit period.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int STOP_BITS            = 1;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous circular-buffer FIFO; a count register separates full from empty
// so the pointers can wrap naturally.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO   = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify requests against the registered occupancy; a push while full is
    // refused even when a pop happens in the same cycle.
    always_comb begin
        push_ok_s = push && (count_r != FULL_COUNT);
        pop_ok_s  = pop  && (count_r != CNT_ZERO);
    end

    // Data storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = (count_r == FULL_COUNT);
    assign empty    = (count_r == CNT_ZERO);

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// LSB-first, back to back, with registered line outputs.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset,
    input  logic                          i_Tx_DV,
    input  logic [DATA_BITS-1:0]          i_Tx_Byte,
    output logic                          o_Tx_Ready,
    output logic                          o_Overflow,
    output logic                          o_Tx_Serial,
    output logic                          o_Tx_Active,
    output logic                          o_Tx_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

    localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

    tx_state_t              state_r;
    tx_state_t              state_s;
    logic [CNT_W-1:0]       clk_cnt_r;
    logic [CNT_W-1:0]       clk_cnt_s;
    logic [2:0]             bit_idx_r;
    logic [2:0]             bit_idx_s;
    logic [DATA_BITS-1:0]   shift_r;
    logic [DATA_BITS-1:0]   shift_s;
    logic                   serial_r;
    logic                   serial_s;
    logic                   active_r;
    logic                   active_s;
    logic                   done_r;
    logic                   done_s;
    logic                   overflow_r;
    logic                   overflow_s;

    logic                   pop_s;
    logic                   push_s;
    logic [DATA_BITS-1:0]   fifo_data_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (i_Clock),
        .rst       (i_Reset),
        .push      (push_s),
        .push_data (i_Tx_Byte),
        .pop       (pop_s),
        .pop_data  (fifo_data_s),
        .count     (o_Fifo_Count),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign o_Tx_Ready = !fifo_full_s;
    assign push_s     = i_Tx_DV && !fifo_full_s;

    // Next-state logic; line outputs are derived from the next state so the
    // registered copies line up exactly with the state they describe.
    always_comb begin
        state_s   = state_r;
        clk_cnt_s = clk_cnt_r;
        bit_idx_s = bit_idx_r;
        shift_s   = shift_r;
        pop_s     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    shift_s   = fifo_data_s;
                    clk_cnt_s = CNT_ZERO;
                    state_s   = ST_START;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == LAST_CLK) begin
                    clk_cnt_s = CNT_ZERO;
                    bit_idx_s = 3'd0;
                    state_s   = ST_DATA;
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == LAST_CLK) begin
                    clk_cnt_s = CNT_ZERO;
                    if (bit_idx_r == LAST_DATA) begin
                        bit_idx_s = 3'd0;
                        state_s   = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == LAST_CLK) begin
                    clk_cnt_s = CNT_ZERO;
                    if (bit_idx_r == LAST_STOP) begin
                        bit_idx_s = 3'd0;
                        // Chain straight into the next frame when data is waiting.
                        if (!fifo_empty_s) begin
                            pop_s   = 1'b1;
                            shift_s = fifo_data_s;
                            state_s = ST_START;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_s = clk_cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                clk_cnt_s = CNT_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase

        case (state_s)
            ST_IDLE:  serial_s = 1'b1;
            ST_START: serial_s = 1'b0;
            ST_DATA:  serial_s = shift_s[bit_idx_s];
            ST_STOP:  serial_s = 1'b1;
            default:  serial_s = 1'b1;
        endcase

        active_s   = (state_s != ST_IDLE);
        done_s     = (state_s == ST_STOP) && (clk_cnt_s == LAST_CLK) && (bit_idx_s == LAST_STOP);
        overflow_s = i_Tx_DV && fifo_full_s;
    end

    // State and output registers; reset forces the line idle at once.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_r    <= ST_IDLE;
            clk_cnt_r  <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            serial_r   <= 1'b1;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            clk_cnt_r  <= clk_cnt_s;
            bit_idx_r  <= bit_idx_s;
            shift_r    <= shift_s;
            serial_r   <= serial_s;
            active_r   <= active_s;
            done_r     <= done_s;
            overflow_r <= overflow_s;
        end
    end

    assign o_Tx_Serial = serial_r;
    assign o_Tx_Active = active_r;
    assign o_Tx_Done   = done_r;
    assign o_Overflow  = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: frame-level reference model,
// reference UART receiver and directed scenarios with literal expectations.
module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          i_Clock   = 1'b0;
    logic          i_Reset   = 1'b1;
    logic          i_Tx_DV   = 1'b0;
    logic [7:0]    i_Tx_Byte = 8'h00;
    logic          o_Tx_Ready;
    logic          o_Overflow;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Tx_Done;
    logic [CW-1:0] o_Fifo_Count;

    uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Tx_DV      (i_Tx_DV),
        .i_Tx_Byte    (i_Tx_Byte),
        .o_Tx_Ready   (o_Tx_Ready),
        .o_Overflow   (o_Overflow),
        .o_Tx_Serial  (o_Tx_Serial),
        .o_Tx_Active  (o_Tx_Active),
        .o_Tx_Done    (o_Tx_Done),
        .o_Fifo_Count (o_Fifo_Count)
    );

    always #5 i_Clock = ~i_Clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the position inside the frame on the line.
    byte unsigned mq[$];
    bit           m_busy = 1'b0;
    int           m_pos  = 0;
    logic [7:0]   m_byte = 8'h00;
    bit           m_ovf  = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    always @(posedge i_Clock or posedge i_Reset) begin : model_step
        int sz;
        if (i_Reset) begin
            mq.delete();
            m_busy = 1'b0;
            m_pos  = 0;
            m_ovf  = 1'b0;
        end else begin
            sz    = mq.size();
            m_ovf = i_Tx_DV && (sz >= DEPTH);
            if (m_busy && m_pos < FRAME - 1) begin
                m_pos++;
            end else if (sz > 0) begin
                m_byte = mq.pop_front();
                m_busy = 1'b1;
                m_pos  = 0;
            end else begin
                m_busy = 1'b0;
                m_pos  = 0;
            end
            if (i_Tx_DV && sz < DEPTH) mq.push_back(i_Tx_Byte);
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge i_Clock) begin
        check("serial",   o_Tx_Serial,  m_busy ? frame_bit(m_byte, m_pos / CPB) : 1'b1);
        check("active",   o_Tx_Active,  m_busy);
        check("done",     o_Tx_Done,    m_busy && (m_pos == FRAME - 1));
        check("overflow", o_Overflow,   m_ovf);
        check("count",    o_Fifo_Count, mq.size());
        check("ready",    o_Tx_Ready,   mq.size() < DEPTH);
    end

    int done_cnt   = 0;
    int active_cnt = 0;
    always @(negedge i_Clock) begin
        if (o_Tx_Done)   done_cnt++;
        if (o_Tx_Active) active_cnt++;
    end

    // Reference receiver: samples each bit in its middle after a falling edge.
    logic [7:0] rx_q[$];
    bit         rx_busy = 1'b0;
    int         rx_cnt  = 0;
    logic [7:0] rx_sh   = 8'h00;
    always @(negedge i_Clock or posedge i_Reset) begin : rx_model
        int k;
        if (i_Reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (o_Tx_Serial == 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                k = rx_cnt / CPB;
                if (k >= 1 && k <= 8) begin
                    rx_sh[k-1] = o_Tx_Serial;
                end else if (k == 9) begin
                    check("rx_stop_bit", o_Tx_Serial, 1'b1);
                    rx_q.push_back(rx_sh);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge i_Clock);
            k++;
        end
        check("rx_timeout", rx_q.size() >= n, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((o_Tx_Active || o_Fifo_Count != 0) && k < budget) begin
            @(negedge i_Clock);
            k++;
        end
        check("idle_timeout", o_Tx_Active || o_Fifo_Count != 0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, a0, unstable, n_done, done_at, act, idx;
        logic [9:0] word;
        logic [7:0] exp_full[6];
        exp_full = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h27};

        // Reset values.
        repeat (3) @(negedge i_Clock);
        check("rst_serial", o_Tx_Serial, 1'b1);
        check("rst_active", o_Tx_Active, 1'b0);
        check("rst_done",   o_Tx_Done,   1'b0);
        check("rst_ovf",    o_Overflow,  1'b0);
        check("rst_count",  o_Fifo_Count, 0);
        check("rst_ready",  o_Tx_Ready,  1'b1);
        i_Reset = 1'b0;
        repeat (3) @(negedge i_Clock);

        // Single byte 0xA5: latency, bit pattern, done position, active width.
        base = rx_q.size();
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'hA5;
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        check("a5_count_after_write", o_Fifo_Count, 1);
        check("a5_line_still_idle",   o_Tx_Serial, 1'b1);
        @(negedge i_Clock);
        check("a5_start_bit", o_Tx_Serial, 1'b0);
        check("a5_count_after_pop", o_Fifo_Count, 0);
        unstable = 0; n_done = 0; done_at = -1; act = 0; word = 10'h000;
        for (int i = 0; i < FRAME + 8; i++) begin
            if (o_Tx_Done) begin n_done++; done_at = i; end
            if (o_Tx_Active) act++;
            if (i < FRAME) begin
                if (i % CPB == 0) word[i / CPB] = o_Tx_Serial;
                else if (o_Tx_Serial != word[i / CPB]) unstable++;
            end
            @(negedge i_Clock);
        end
        check("a5_bits",     word, 10'b1101001010);
        check("a5_bit_hold", unstable, 0);
        check("a5_done_cnt", n_done, 1);
        check("a5_done_pos", done_at, FRAME - 1);
        check("a5_active",   act, FRAME);
        check("a5_rx",       rx_q[base], 8'hA5);

        // Burst of six: one in flight, four queued, one dropped.
        wait_idle(100);
        base = rx_q.size(); d0 = done_cnt; a0 = active_cnt;
        for (int v = 1; v <= 6; v++) begin
            i_Tx_DV = 1'b1; i_Tx_Byte = 8'(v);
            @(negedge i_Clock);
        end
        i_Tx_DV = 1'b0;
        check("burst_overflow", o_Overflow, 1'b1);
        check("burst_count",    o_Fifo_Count, 4);
        check("burst_ready",    o_Tx_Ready, 1'b0);
        @(negedge i_Clock);
        check("burst_overflow_width", o_Overflow, 1'b0);
        wait_rx(base + 5, 400);
        for (int i = 0; i < 5; i++) check("burst_byte", rx_q[base + i], 8'(i + 1));
        wait_idle(100);
        check("burst_done_cnt", done_cnt - d0, 5);
        check("burst_active",   active_cnt - a0, 5 * FRAME);

        // Full FIFO with a push landing on the STOP->START pop edge.
        base = rx_q.size();
        for (int v = 0; v < 5; v++) begin
            i_Tx_DV = 1'b1; i_Tx_Byte = 8'h21 + 8'(v);
            @(negedge i_Clock);
        end
        i_Tx_DV = 1'b0;
        check("full_count", o_Fifo_Count, 4);
        idx = 0;
        while (!o_Tx_Done && idx < 60) begin
            @(negedge i_Clock);
            idx++;
        end
        check("full_done_seen", o_Tx_Done, 1'b1);
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h26;
        @(negedge i_Clock);
        check("full_reject_ovf",   o_Overflow, 1'b1);
        check("full_reject_count", o_Fifo_Count, 3);
        i_Tx_Byte = 8'h27;
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        check("full_refill_count", o_Fifo_Count, 4);
        check("full_refill_ready", o_Tx_Ready, 1'b0);
        check("full_refill_ovf",   o_Overflow, 1'b0);
        wait_rx(base + 6, 400);
        for (int i = 0; i < 6; i++) check("full_byte", rx_q[base + i], exp_full[i]);
        wait_idle(100);

        // Pointer wrap: twelve bytes streamed with top-up on ready.
        base = rx_q.size();
        idx = 0;
        for (int c = 0; c < 1000 && idx < 12; c++) begin
            if (o_Tx_Ready) begin
                i_Tx_DV = 1'b1; i_Tx_Byte = 8'h10 + 8'(idx);
                idx++;
            end else begin
                i_Tx_DV = 1'b0;
            end
            @(negedge i_Clock);
        end
        i_Tx_DV = 1'b0;
        wait_rx(base + 12, 600);
        for (int i = 0; i < 12; i++) check("wrap_byte", rx_q[base + i], 8'h10 + 8'(i));
        wait_idle(100);

        // Reset during data bit 3 of 0x3C with two bytes queued.
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h3C; @(negedge i_Clock);
        i_Tx_Byte = 8'h11;                 @(negedge i_Clock);
        i_Tx_Byte = 8'h22;                 @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        idx = 0;
        while (o_Tx_Serial && idx < 20) begin
            @(negedge i_Clock);
            idx++;
        end
        check("rst_mid_start_seen", o_Tx_Serial, 1'b0);
        repeat (4 * CPB + 1) @(negedge i_Clock);
        check("rst_mid_queued", o_Fifo_Count, 2);
        d0 = done_cnt;
        #1 i_Reset = 1'b1;
        #1;
        check("rst_mid_serial", o_Tx_Serial, 1'b1);
        check("rst_mid_count",  o_Fifo_Count, 0);
        check("rst_mid_active", o_Tx_Active, 1'b0);
        repeat (3) @(negedge i_Clock);
        i_Reset = 1'b0;
        repeat (2 * FRAME) @(negedge i_Clock);
        check("rst_mid_no_done", done_cnt - d0, 0);
        base = rx_q.size();
        i_Tx_DV = 1'b1; i_Tx_Byte = 8'h55;
        @(negedge i_Clock);
        i_Tx_DV = 1'b0;
        wait_rx(base + 1, 100);
        check("rst_mid_after_byte", rx_q[base], 8'h55);
        wait_idle(100);
        check("rst_mid_after_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
